// File: rtl/tmr_pkg.sv
// Shared types and helpers for the TMR scrub/repair controller.
package tmr_pkg;

  typedef enum logic [1:0] {
    MONITOR,
    CONFIRM,
    RESYNC,
    SETTLE
  } tmr_state_e;

  // Increment that sticks at max instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
    return (val == max) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/tmr_scrub_ctrl_if.sv
// Replica-side bus: the three replica outputs in, the voted value and per-replica load selects out.
interface tmr_scrub_ctrl_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] rep_0;
  logic [WIDTH-1:0] rep_1;
  logic [WIDTH-1:0] rep_2;
  logic [WIDTH-1:0] voted;
  logic [2:0]       resync_sel;

  modport master (
    input  rep_0, rep_1, rep_2,
    output voted, resync_sel
  );

  modport slave (
    output rep_0, rep_1, rep_2,
    input  voted, resync_sel
  );
endinterface

// File: rtl/tmr_vote_cmp.sv
// Bitwise 2-of-3 majority and per-replica disagreement flags; purely combinational.
module tmr_vote_cmp #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] voted_o,
  output logic [2:0]       mism_o
);

  always_comb begin
    voted_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    mism_o  = {c_i != voted_o, b_i != voted_o, a_i != voted_o};
  end

endmodule

// File: rtl/tmr_scrub_ctrl.sv
// Scrub/repair controller for a triplicated register: confirms disagreements, reloads
// faulty replicas with the voted value, tracks error counts and retires stuck replicas.
module tmr_scrub_ctrl
  import tmr_pkg::*;
#(
  parameter int unsigned WIDTH        = 1,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned FAIL_THRESH  = 3,
  parameter int unsigned SCRUB_PERIOD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr_err,
  tmr_scrub_ctrl_if.master  bus,
  output logic [CNT_W-1:0]  err_cnt_0,
  output logic [CNT_W-1:0]  err_cnt_1,
  output logic [CNT_W-1:0]  err_cnt_2,
  output logic [2:0]        fail,
  output logic              busy
);

  localparam int unsigned SCNT_W = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'((SCRUB_PERIOD > 0) ? SCRUB_PERIOD - 1 : 0);
  localparam logic [CNT_W-1:0]  CNT_ONES  = '1;
  localparam logic [2:0]        CF_MAX    = 3'(FAIL_THRESH);

  logic [WIDTH-1:0]  voted;
  logic [2:0]        mism;
  logic [2:0]        mask;

  tmr_state_e        state_q, state_d;
  logic [2:0]        pend_q, pend_d;
  logic [2:0]        sel_q, sel_d;
  logic [2:0]        fail_q, fail_d;
  logic              scrub_q, scrub_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [CNT_W-1:0]  err_q [3];
  logic [CNT_W-1:0]  err_d [3];
  logic [2:0]        cf_q  [3];
  logic [2:0]        cf_d  [3];
  logic [2:0]        cnt_mask;

  tmr_vote_cmp #(.WIDTH(WIDTH)) u_vote (
    .a_i     (bus.rep_0),
    .b_i     (bus.rep_1),
    .c_i     (bus.rep_2),
    .voted_o (voted),
    .mism_o  (mism)
  );

  assign mask = mism & ~fail_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MONITOR;
      pend_q  <= '0;
      sel_q   <= '0;
      fail_q  <= '0;
      scrub_q <= 1'b0;
      scnt_q  <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        err_q[i] <= '0;
        cf_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      fail_q  <= fail_d;
      scrub_q <= scrub_d;
      scnt_q  <= scnt_d;
      err_q   <= err_d;
      cf_q    <= cf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    sel_d    = '0;
    fail_d   = fail_q;
    scrub_d  = scrub_q;
    scnt_d   = scnt_q;
    err_d    = err_q;
    cf_d     = cf_q;
    cnt_mask = '0;

    if (!en) begin
      state_d = MONITOR;
      pend_d  = '0;
      scrub_d = 1'b0;
    end else begin
      unique case (state_q)
        MONITOR: begin
          // A disagreement on a retired replica still blocks scrubbing, but never triggers repair.
          if (mism != '0) scnt_d = '0;
          if (mask != '0) begin
            pend_d  = mask;
            scrub_d = 1'b0;
            state_d = CONFIRM;
          end else if (SCRUB_PERIOD != 0 && mism == '0 && scnt_q == SCNT_LAST) begin
            pend_d  = ~fail_q;
            sel_d   = ~fail_q;
            scrub_d = 1'b1;
            scnt_d  = '0;
            state_d = RESYNC;
          end else if (mism == '0) begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
        CONFIRM: begin
          pend_d = pend_q & mask;
          if (pend_d != '0) begin
            sel_d   = pend_d;
            state_d = RESYNC;
          end else begin
            state_d = MONITOR;
          end
        end
        RESYNC: begin
          cnt_mask = scrub_q ? (pend_q & mask) : pend_q;
          for (int unsigned i = 0; i < 3; i++) begin
            if (cnt_mask[i]) err_d[i] = CNT_W'(sat_inc(32'(err_q[i]), 32'(CNT_ONES)));
          end
          state_d = SETTLE;
        end
        SETTLE: begin
          for (int unsigned i = 0; i < 3; i++) begin
            if (pend_q[i]) begin
              if (mism[i]) begin
                if (cf_q[i] != CF_MAX) cf_d[i] = cf_q[i] + 3'd1;
                if (cf_q[i] >= CF_MAX - 3'd1) fail_d[i] = 1'b1;
              end else begin
                cf_d[i] = '0;
              end
            end
          end
          pend_d  = '0;
          scrub_d = 1'b0;
          state_d = MONITOR;
        end
        default: state_d = MONITOR;
      endcase
    end

    if (clr_err) begin
      fail_d = '0;
      for (int unsigned i = 0; i < 3; i++) begin
        err_d[i] = '0;
        cf_d[i]  = '0;
      end
    end
  end

  assign bus.voted      = voted;
  assign bus.resync_sel = sel_q;
  assign err_cnt_0      = err_q[0];
  assign err_cnt_1      = err_q[1];
  assign err_cnt_2      = err_q[2];
  assign fail           = fail_q;
  assign busy           = (state_q != MONITOR);

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Scoreboarded bench for tmr_scrub_ctrl: emulates the replica registers, predicts every
// cycle's outputs from a timestamp-based repair-episode model, and checks them on negedge.
module tb_tmr_scrub_ctrl;

  localparam int W    = 4;
  localparam int CW   = 8;
  localparam int FT   = 3;
  localparam int SP   = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          clr_err;
  logic [CW-1:0] err_cnt_0, err_cnt_1, err_cnt_2;
  logic [2:0]    fail;
  logic          busy;

  tmr_scrub_ctrl_if #(.WIDTH(W)) bus ();

  tmr_scrub_ctrl #(
    .WIDTH        (W),
    .CNT_W        (CW),
    .FAIL_THRESH  (FT),
    .SCRUB_PERIOD (SP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr_err   (clr_err),
    .bus       (bus),
    .err_cnt_0 (err_cnt_0),
    .err_cnt_1 (err_cnt_1),
    .err_cnt_2 (err_cnt_2),
    .fail      (fail),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [W-1:0]  voted;
    logic [2:0]    sel;
    logic [CW-1:0] e0, e1, e2;
    logic [2:0]    fail;
    logic          busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks   = 0;
  int   failures = 0;

  // Replica emulation and reference-model state
  logic [W-1:0] r        [3];
  logic [W-1:0] glitch   [3];
  logic [W-1:0] stuck_val[3];
  bit           stuck    [3];
  int           m_err[3], m_cf[3];
  logic [2:0]   m_fail, m_pend, m_sel;
  bit           m_scrub;
  int           m_scnt;
  int           t_confirm, t_resync, t_settle, t_idle;
  int           cyc;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, c, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      chk("voted",      cur.cyc, 32'(bus.voted),      32'(cur.voted));
      chk("resync_sel", cur.cyc, 32'(bus.resync_sel), 32'(cur.sel));
      chk("err_cnt_0",  cur.cyc, 32'(err_cnt_0),      32'(cur.e0));
      chk("err_cnt_1",  cur.cyc, 32'(err_cnt_1),      32'(cur.e1));
      chk("err_cnt_2",  cur.cyc, 32'(err_cnt_2),      32'(cur.e2));
      chk("fail",       cur.cyc, 32'(fail),           32'(cur.fail));
      chk("busy",       cur.cyc, 32'(busy),           32'(cur.busy));
    end
  end

  function automatic logic [W-1:0] maj3(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    logic [W-1:0] res;
    int n;
    for (int k = 0; k < W; k++) begin
      n = int'(a[k]) + int'(b[k]) + int'(c[k]);
      res[k] = (n >= 2);
    end
    return res;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_err[i] = 0;
      m_cf[i]  = 0;
    end
    m_fail = '0; m_pend = '0; m_sel = '0; m_scrub = 0; m_scnt = 0;
    t_confirm = -1; t_resync = -1; t_settle = -1; t_idle = cyc + 1;
  endtask

  // One clock cycle: present inputs, predict outputs, advance model and replicas.
  task automatic step();
    logic [W-1:0] p[3];
    logic [W-1:0] v;
    logic [2:0]   mism, mask, cnt, nsel;
    bit           bz;
    exp_t         e;
    for (int i = 0; i < 3; i++) p[i] = stuck[i] ? stuck_val[i] : (r[i] ^ glitch[i]);
    bus.rep_0 = p[0];
    bus.rep_1 = p[1];
    bus.rep_2 = p[2];
    v = maj3(p[0], p[1], p[2]);
    for (int i = 0; i < 3; i++) mism[i] = (p[i] != v);
    mask = mism & ~m_fail;
    bz   = (cyc < t_idle);

    e.cyc = cyc; e.voted = v; e.sel = m_sel; e.fail = m_fail; e.busy = bz;
    e.e0 = CW'(m_err[0]); e.e1 = CW'(m_err[1]); e.e2 = CW'(m_err[2]);
    exp_q.push_back(e);

    nsel = '0;
    if (rst) begin
      model_reset();
    end else if (!en) begin
      m_pend = '0; m_scrub = 0;
      t_confirm = -1; t_resync = -1; t_settle = -1;
      if (bz) t_idle = cyc + 1;
    end else if (!bz) begin
      if (mask != '0) begin
        m_pend = mask; m_scrub = 0; m_scnt = 0;
        t_confirm = cyc + 1; t_idle = cyc + 4;
      end else if (mism != '0) begin
        m_scnt = 0;
      end else if (m_scnt == SP - 1) begin
        m_scnt = 0; m_pend = ~m_fail; m_scrub = 1; nsel = m_pend;
        t_resync = cyc + 1; t_settle = cyc + 2; t_idle = cyc + 3;
      end else begin
        m_scnt++;
      end
    end else if (cyc == t_confirm) begin
      m_pend &= mask;
      if (m_pend != '0) begin
        nsel = m_pend; t_resync = cyc + 1; t_settle = cyc + 2;
      end else begin
        t_idle = cyc + 1;
      end
    end else if (cyc == t_resync) begin
      cnt = m_scrub ? (m_pend & mask) : m_pend;
      for (int i = 0; i < 3; i++) if (cnt[i] && m_err[i] < CMAX) m_err[i]++;
    end else if (cyc == t_settle) begin
      for (int i = 0; i < 3; i++) begin
        if (m_pend[i]) begin
          if (mism[i]) begin
            if (m_cf[i] < FT) m_cf[i]++;
            if (m_cf[i] >= FT) m_fail[i] = 1'b1;
          end else begin
            m_cf[i] = 0;
          end
        end
      end
      m_pend = '0; m_scrub = 0;
    end
    if (clr_err && !rst) begin
      m_fail = '0;
      for (int i = 0; i < 3; i++) begin
        m_err[i] = 0;
        m_cf[i]  = 0;
      end
    end

    for (int i = 0; i < 3; i++) begin
      if (m_sel[i]) r[i] = v;
      glitch[i] = '0;
    end
    m_sel = nsel;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cyc < t_idle && n < 50) begin
      step();
      n++;
    end
    if (cyc < t_idle) chk("idle_wait", cyc, 32'(busy), 32'd0);
  endtask

  task automatic run_to_resync();
    int n = 0;
    while (cyc != t_resync && n < 10) begin
      step();
      n++;
    end
    chk("reach_resync", cyc, 32'(cyc), 32'(t_resync));
  endtask

  int unsigned k, idx, idx2;
  logic [W-1:0] flip;

  initial begin
    rst = 1'b1; en = 1'b1; clr_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r[i] = 4'hA; glitch[i] = '0; stuck[i] = 0; stuck_val[i] = '0;
    end
    bus.rep_0 = r[0]; bus.rep_1 = r[1]; bus.rep_2 = r[2];
    cyc = 0;
    model_reset();
    t_idle = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Clean replicas: first preventive scrub lands on cycle 16
    chk("reset_busy", cyc, 32'(busy), 32'd0);
    chk("reset_sel",  cyc, 32'(bus.resync_sel), 32'd0);
    repeat (16) step();
    chk("scrub_sel", cyc, 32'(bus.resync_sel), 32'h7);
    step();
    chk("scrub_one_cycle", cyc, 32'(bus.resync_sel), 32'd0);
    repeat (3) step();
    chk("scrub_no_count", cyc, 32'({err_cnt_0, err_cnt_1, err_cnt_2}), 32'd0);

    // Single persistent upset on rep_1
    wait_idle();
    r[1] = 4'h2;
    step(); step();
    chk("upset_voted", cyc, 32'(bus.voted), 32'hA);
    chk("upset_sel",   cyc, 32'(bus.resync_sel), 32'h2);
    wait_idle();
    chk("upset_err1",  cyc, 32'(err_cnt_1), 32'd1);

    // One-cycle transient on rep_2
    wait_idle();
    glitch[2] = 4'h5;
    step(); step();
    chk("transient_sel", cyc, 32'(bus.resync_sel), 32'd0);
    chk("transient_busy", cyc, 32'(busy), 32'd0);
    repeat (3) step();
    chk("transient_err2", cyc, 32'(err_cnt_2), 32'd0);

    // rep_0 ignores reloads: retired after three unsuccessful repairs
    wait_idle();
    stuck[0] = 1; stuck_val[0] = 4'h3;
    repeat (12) step();
    chk("stuck_fail", cyc, 32'(fail), 32'h1);
    repeat (20) step();
    chk("stuck_busy", cyc, 32'(busy), 32'd0);
    chk("stuck_sel",  cyc, 32'(bus.resync_sel), 32'd0);
    chk("stuck_err0", cyc, 32'(err_cnt_0), 32'd3);
    stuck[0] = 0;
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("clr_fail", cyc, 32'(fail), 32'd0);

    // Drive err_cnt_1 into saturation
    repeat (CMAX + 5) begin
      wait_idle();
      r[1] ^= W'($urandom_range(1, 15));
      step();
    end
    wait_idle();
    chk("saturate_err1", cyc, 32'(err_cnt_1), 32'hFF);

    // clr_err coinciding with a RESYNC cycle wins over the increment
    wait_idle();
    r[1] ^= W'($urandom_range(1, 15));
    run_to_resync();
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("clr_on_resync", cyc, 32'(err_cnt_1), 32'd0);

    // Reset landing on a RESYNC cycle
    wait_idle();
    r[0] ^= 4'h1;
    step();
    wait_idle();
    chk("pre_rst_err0", cyc, 32'(err_cnt_0), 32'd1);
    r[2] ^= 4'h6;
    run_to_resync();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_sel",  cyc, 32'(bus.resync_sel), 32'd0);
    chk("rst_busy", cyc, 32'(busy), 32'd0);
    chk("rst_err",  cyc, 32'({err_cnt_0, err_cnt_1, err_cnt_2}), 32'd0);
    wait_idle();

    // Disabled controller ignores a standing mismatch
    en = 1'b0;
    r[0] ^= 4'h8;
    repeat (8) step();
    chk("dis_busy", cyc, 32'(busy), 32'd0);
    chk("dis_sel",  cyc, 32'(bus.resync_sel), 32'd0);
    en = 1'b1;
    repeat (6) step();
    wait_idle();
    chk("reen_err0", cyc, 32'(err_cnt_0), 32'd1);

    // Random mix of upsets, transients, enable drops, clears and resets
    repeat (900) begin
      k    = $urandom_range(0, 99);
      idx  = $urandom_range(0, 2);
      flip = W'($urandom_range(1, 15));
      if (k < 10) begin
        r[idx] ^= flip;
      end else if (k < 14) begin
        glitch[idx] = flip;
      end else if (k == 14) begin
        idx2 = (idx + 1) % 3;
        r[idx] ^= flip;
        r[idx2] ^= flip;
      end
      en      = ($urandom_range(0, 24) != 0);
      clr_err = ($urandom_range(0, 59) == 0);
      rst     = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; en = 1'b1; clr_err = 1'b0;
    repeat (10) step();

    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", cyc, 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmr_scrub_ctrl.md
# tmr_scrub_ctrl

Scrub and repair controller for a triplicated single-clock register stage with bitwise majority voting. It compares the three replica register outputs against their majority each cycle and confirms any disagreement over a second cycle. A confirmed disagreement triggers a one-cycle reload of the faulty replica(s) with the voted value. The block keeps per-replica saturating error counts, declares a replica permanently failed after repeated unsuccessful repairs, and issues periodic preventive scrubs; it sits beside the replica registers and drives their load-select muxes.

## Interface
- WIDTH, 1: bits per replica.
- CNT_W, 8: width of each error counter.
- FAIL_THRESH, 3: consecutive failed repairs before a replica is declared failed (1..7).
- SCRUB_PERIOD, 16: cycles of clean MONITOR between preventive scrubs; 0 disables scrubbing.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  controller enable; low holds FSM in MONITOR and suppresses all resync.
- clr_err  in  1  clears err_cnt_*, fail and consecutive-fail counters.
- rep_0, rep_1, rep_2  in  WIDTH  replica register outputs.
- voted  out  WIDTH  bitwise 2-of-3 majority, combinational.
- resync_sel  out  3  per-replica load enable; replica i loads voted when bit i is 1.
- err_cnt_0, err_cnt_1, err_cnt_2  out  CNT_W  saturating repair counts.
- fail  out  3  sticky per-replica failed flags.
- busy  out  1  high whenever state is not MONITOR.

## Operation
- mism[i] = (rep_i != voted) over any bit; mask = mism & ~fail.
- States: MONITOR, CONFIRM, RESYNC, SETTLE.
- MONITOR: if en and mask != 0, latch pend = mask and go to CONFIRM. Otherwise, if en and SCRUB_PERIOD != 0 and the scrub counter reaches SCRUB_PERIOD-1, set pend = ~fail, clear the counter and go to RESYNC as a scrub.
- Scrub counter increments only in MONITOR with en=1 and mask=0; it is held in other states and cleared on any mismatch.
- CONFIRM: pend &= mask. If the result is nonzero, go to RESYNC; otherwise it was a transient, so return to MONITOR with no count.
- RESYNC: resync_sel = pend for exactly this cycle. err_cnt_i += 1 (saturating at all-ones) for each pend bit, except on scrubs where mask was 0. Go to SETTLE.
- SETTLE: re-evaluate mism for the pend replicas.
  - Still mismatched: the consecutive-fail counter for that replica increments; on reaching FAIL_THRESH, set fail[i].
  - Matched: the consecutive-fail counter for that replica clears.
  - Return to MONITOR.
- Failed replicas are never selected for resync. voted stays the plain 3-input majority.
- en falling in any state: the next state is MONITOR, resync_sel = 0, pend cleared.
- clr_err: takes priority over a same-cycle increment; counters and flags become 0.

## Timing
- Reset values: state MONITOR, resync_sel 0, err_cnt_* 0, fail 0, busy 0, scrub counter 0, consecutive-fail counters 0, pend 0.
- voted: zero latency from the rep_* inputs.
- resync_sel: registered; asserted in the cycle after CONFIRM, i.e. 2 cycles after the mismatch first appears in MONITOR.
- The replica loads on the clock edge ending the RESYNC cycle; SETTLE samples the reloaded value.
- Full repair loop is 4 cycles from MONITOR back to MONITOR; a new mismatch is not accepted while busy.
- rst mid-operation: all state returns to reset values on that edge, and resync_sel is deasserted.
- A simultaneous mismatch on two replicas makes the third the minority. Mask then flags only that replica, so a true double upset is indistinguishable and is not repaired.

## Structure
- Package tmr_pkg holds the state enum (MONITOR, CONFIRM, RESYNC, SETTLE) and the saturating-increment helper function.
- Sub-module tmr_vote_cmp: combinational bitwise majority plus the 3-bit mism vector; it is reusable by other TMR stages.
- Top level holds the FSM, scrub counter, pend register, err counters and fail logic.

## Test plan
- Reset, WIDTH=4, all reps 4'hA for 20 cycles, SCRUB_PERIOD=16 -> one scrub: resync_sel=3'b111 for 1 cycle at cycle 16 after reset release, err_cnt all 0.
- rep_1 = 4'h2 against 4'hA held until reload -> voted=4'hA; resync_sel=3'b010 two cycles later; err_cnt_1=1; consecutive-fail counter for rep_1 clear.
- rep_2 differs for 1 cycle only -> CONFIRM returns to MONITOR, resync_sel never asserted, err_cnt_2=0.
- rep_0 stuck wrong (ignores load) -> three repair loops, then fail=3'b001; further mismatches on rep_0 produce no resync_sel; busy low.
- err_cnt_1 preloaded near all-ones by repeated upsets -> saturates at 8'hFF. Assert clr_err on the same cycle as a RESYNC -> counter reads 0.
- rst asserted during RESYNC -> next cycle resync_sel=0, state MONITOR, all counters 0. en=0 with a mismatch present -> no resync, busy=0.
